// File: rtl/control_sequencer_if.sv
// control_sequencer_if: instruction/memory inputs and datapath control strobes of the sequencer
interface control_sequencer_if #(parameter int ALUW = 4);
  logic [31:0] ir;
  logic mem_rdy;
  logic Gra, Grb, Grc, Rin, Rout, BAout;
  logic PCout, PCin, IncPC, MARin, MDRin, MDRout, IRin, Yin, Zin, Zlowout, Cout;
  logic Read, Write;
  logic [ALUW-1:0] alu_op;
  logic run, illegal;
  modport master(
    input ir, mem_rdy,
    output Gra, Grb, Grc, Rin, Rout, BAout, PCout, PCin, IncPC, MARin, MDRin, MDRout,
    output IRin, Yin, Zin, Zlowout, Cout, Read, Write, alu_op, run, illegal
  );
  modport slave(
    output ir, mem_rdy,
    input Gra, Grb, Grc, Rin, Rout, BAout, PCout, PCin, IncPC, MARin, MDRin, MDRout,
    input IRin, Yin, Zin, Zlowout, Cout, Read, Write, alu_op, run, illegal
  );
endinterface

// File: rtl/control_sequencer.sv
// control_sequencer: Mini SRC T-state control unit; ILLEGAL_TRAP_EN halts on undefined opcodes with a sticky flag
module control_sequencer #(
  parameter int OPW = 5,
  parameter int ALUW = 4
) (
  input  logic clk,
  input  logic reset,
  control_sequencer_if.master bus
);
  typedef enum logic [3:0] {T0, T1, T2, T3, T4, T5, T6, T7, HALT} state_t;
  state_t state;
  logic t1_first;
  logic [OPW-1:0] op;
  logic rtype, itype, ldi, ld, st, hlt, mem, exec, alu_path;
  logic s0, s1, s2, s3, s4, s5, s6, s7;
  assign op = bus.ir[31 -: OPW];
  assign rtype = op inside {[OPW'(3):OPW'(6)]};
  assign itype = op inside {[OPW'(12):OPW'(14)]};
  assign ldi = op == OPW'(1);
  assign ld = op == OPW'(0);
  assign st = op == OPW'(2);
  assign hlt = op == OPW'(27);
  assign mem = ld | st;
  assign alu_path = rtype | itype | ldi;
  assign exec = alu_path | mem;
  // Outputs are gated by reset so an aborted request drops in the reset cycle itself
  assign s0 = !reset && state == T0;
  assign s1 = !reset && state == T1;
  assign s2 = !reset && state == T2;
  assign s3 = !reset && state == T3;
  assign s4 = !reset && state == T4;
  assign s5 = !reset && state == T5;
  assign s6 = !reset && state == T6;
  assign s7 = !reset && state == T7;
  assign bus.Gra = (s5 & alu_path) | (s6 & st) | (s7 & ld);
  assign bus.Grb = s3 & exec;
  assign bus.Grc = s4 & rtype;
  assign bus.Rin = (s5 & alu_path) | (s7 & ld);
  assign bus.Rout = (s3 & (rtype | itype)) | (s4 & rtype) | (s6 & st);
  assign bus.BAout = s3 & (ldi | mem);
  assign bus.PCout = s0;
  assign bus.PCin = s1 & t1_first;
  assign bus.IncPC = s0;
  assign bus.MARin = s0 | (s5 & mem);
  assign bus.MDRin = s1 | (s6 & mem);
  assign bus.MDRout = s2 | (s7 & ld);
  assign bus.IRin = s2;
  assign bus.Yin = s3 & exec;
  assign bus.Zin = s0 | (s4 & exec);
  assign bus.Zlowout = s1 | (s5 & exec);
  assign bus.Cout = s4 & (itype | ldi | mem);
  assign bus.Read = s1 | (s6 & ld);
  assign bus.Write = s7 & st;
  // Opcodes within each ALU group are ordered so an offset yields ADD/SUB/AND/OR; addi has no SUB slot
  assign bus.alu_op = !s4 ? '0 :
                      rtype ? ALUW'(op - OPW'(3)) :
                      (itype && op != OPW'(12)) ? ALUW'(op - OPW'(11)) : '0;
  assign bus.run = state != HALT;
`ifdef ILLEGAL_TRAP_EN
  logic trap;
  logic known;
  assign known = exec | hlt | op == OPW'(26);
  assign bus.illegal = trap & !reset;
`else
  assign bus.illegal = 1'b0;
`endif
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= T0;
      t1_first <= 1'b0;
`ifdef ILLEGAL_TRAP_EN
      trap <= 1'b0;
`endif
    end else begin
      t1_first <= state == T0;
      case (state)
        T0: state <= T1;
        T1: state <= bus.mem_rdy ? T2 : T1;
        T2: state <= T3;
        T3: begin
          state <= hlt ? HALT : exec ? T4 : T0;
`ifdef ILLEGAL_TRAP_EN
          if (!known) begin
            state <= HALT;
            trap <= 1'b1;
          end
`endif
        end
        T4: state <= T5;
        T5: state <= mem ? T6 : T0;
        T6: state <= (st | bus.mem_rdy) ? T7 : T6;
        T7: state <= (ld | bus.mem_rdy) ? T0 : T7;
        HALT: state <= HALT;
        default: state <= T0;
      endcase
    end
  end
endmodule

// File: tb/tb_control_sequencer.sv
// tb_control_sequencer: per-cycle expected-strobe trace built from micro-op tables, compared against the DUT
module tb_control_sequencer;
  localparam logic [24:0] GRA = 25'd1 << 0, GRB = 25'd1 << 1, GRC = 25'd1 << 2, RIN = 25'd1 << 3;
  localparam logic [24:0] ROUT = 25'd1 << 4, BAOUT = 25'd1 << 5, PCOUT = 25'd1 << 6, PCIN = 25'd1 << 7;
  localparam logic [24:0] INCPC = 25'd1 << 8, MARIN = 25'd1 << 9, MDRIN = 25'd1 << 10, MDROUT = 25'd1 << 11;
  localparam logic [24:0] IRIN = 25'd1 << 12, YIN = 25'd1 << 13, ZIN = 25'd1 << 14, ZLOW = 25'd1 << 15;
  localparam logic [24:0] COUT = 25'd1 << 16, READ = 25'd1 << 17, WRITE = 25'd1 << 18;
  localparam logic [24:0] RUN = 25'd1 << 23, ILL = 25'd1 << 24, ALL = '1;
  typedef struct {
    logic rst;
    logic rdy;
    logic [31:0] ir;
    logic [24:0] exp;
    logic [24:0] msk;
    int tag;
  } rec_t;
  logic clk = 1'b0;
  logic reset = 1'b1;
  rec_t q[$];
  int checks = 0, passed = 0;
  int cyc[10], rd[10], wr[10], rin[10], pcin[10], runlo[10], ill[10];
  control_sequencer_if b();
  control_sequencer dut(.clk(clk), .reset(reset), .bus(b));
  always #5 clk = ~clk;
  function automatic logic rnd();
    return $urandom_range(0, 1) == 1;
  endfunction
  function automatic logic [24:0] alu_of(input logic [4:0] op);
    case (op)
      5'd4: return 25'd1 << 19;
      5'd5, 5'd13: return 25'd2 << 19;
      5'd6, 5'd14: return 25'd3 << 19;
      default: return '0;
    endcase
  endfunction
  task automatic push(input logic rst, input logic rdy, input logic [31:0] ir, input logic [24:0] e,
                      input logic [24:0] m, input int tag);
    rec_t r;
    r.rst = rst; r.rdy = rdy; r.ir = ir; r.exp = e; r.msk = m; r.tag = tag;
    q.push_back(r);
  endtask
  task automatic resets(input int n, input logic rdy, input int tag);
    for (int i = 0; i < n; i++) push(1'b1, rdy, 32'h0, '0, ~RUN, tag);
  endtask
  task automatic halted(input int n, input logic [24:0] e, input int tag);
    for (int i = 0; i < n; i++) push(1'b0, rnd(), 32'h0, e, ALL, tag);
  endtask
  task automatic instr(input logic [31:0] ir, input int w1, input int w, input int tag);
    logic [4:0] op;
    logic r_t, i_t;
    op = ir[31:27];
    r_t = op >= 5'd3 && op <= 5'd6;
    i_t = op >= 5'd12 && op <= 5'd14;
    push(1'b0, rnd(), ir, RUN | PCOUT | MARIN | INCPC | ZIN, ALL, tag);
    for (int i = 0; i <= w1; i++)
      push(1'b0, i == w1, ir, RUN | ZLOW | READ | MDRIN | (i == 0 ? PCIN : '0), ALL, tag);
    push(1'b0, rnd(), ir, RUN | MDROUT | IRIN, ALL, tag);
    if (r_t || i_t) begin
      push(1'b0, rnd(), ir, RUN | GRB | ROUT | YIN, ALL, tag);
      push(1'b0, rnd(), ir, RUN | (r_t ? GRC | ROUT : COUT) | ZIN | alu_of(op), ALL, tag);
      push(1'b0, rnd(), ir, RUN | ZLOW | GRA | RIN, ALL, tag);
    end else if (op <= 5'd2) begin
      push(1'b0, rnd(), ir, RUN | GRB | BAOUT | YIN, ALL, tag);
      push(1'b0, rnd(), ir, RUN | COUT | ZIN, ALL, tag);
      push(1'b0, rnd(), ir, RUN | ZLOW | (op == 5'd1 ? GRA | RIN : MARIN), ALL, tag);
      if (op == 5'd0) begin
        for (int i = 0; i <= w; i++) push(1'b0, i == w, ir, RUN | READ | MDRIN, ALL, tag);
        push(1'b0, rnd(), ir, RUN | MDROUT | GRA | RIN, ALL, tag);
      end else if (op == 5'd2) begin
        push(1'b0, rnd(), ir, RUN | GRA | ROUT | MDRIN, ALL, tag);
        for (int i = 0; i <= w; i++) push(1'b0, i == w, ir, RUN | WRITE, ALL, tag);
      end
    end else begin
      push(1'b0, rnd(), ir, RUN, ALL, tag);
    end
  endtask
  task automatic chk(input string n, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got === want) passed++;
    else $display("FAIL %s: got %0h want %0h", n, got, want);
  endtask
  initial begin
    logic [31:0] ops[8];
    logic [24:0] v;
    ops = '{32'h20000000, 32'h28000000, 32'h30000000, 32'h60000000,
            32'h68000000, 32'h70000000, 32'h08000000, 32'hD0000000};
    foreach (cyc[i]) begin
      cyc[i] = 0; rd[i] = 0; wr[i] = 0; rin[i] = 0; pcin[i] = 0; runlo[i] = 0; ill[i] = 0;
    end
    b.ir = '0;
    b.mem_rdy = 1'b1;
    resets(2, 1'b1, 0);
    instr(32'h18910000, 0, 0, 1);
    instr(32'h02100008, 0, 3, 2);
    instr(32'h12800010, 1, 2, 3);
    foreach (ops[i]) instr(ops[i], $urandom_range(0, 2), 0, 6);
    instr(32'hD8000000, 0, 0, 4);
    halted(20, '0, 4);
    resets(1, 1'b1, 0);
    instr(32'h18910000, 0, 0, 7);
    instr(32'h12800010, 0, 3, 8);
    repeat (3) void'(q.pop_back());
    resets(1, 1'b0, 0);
    instr(32'h18910000, 0, 0, 5);
    instr(32'hF8000000, 0, 0, 9);
`ifdef ILLEGAL_TRAP_EN
    halted(5, ILL, 9);
    resets(1, 1'b1, 0);
`endif
    instr(32'h18910000, 1, 0, 7);
    foreach (q[i]) begin
      @(posedge clk);
      #1;
      reset = q[i].rst;
      b.mem_rdy = q[i].rdy;
      b.ir = q[i].ir;
      @(negedge clk);
      v = {b.illegal, b.run, b.alu_op, b.Write, b.Read, b.Cout, b.Zlowout, b.Zin, b.Yin, b.IRin,
           b.MDRout, b.MDRin, b.MARin, b.IncPC, b.PCin, b.PCout, b.BAout, b.Rout, b.Rin, b.Grc, b.Grb, b.Gra};
      chk($sformatf("cycle%0d_tag%0d", i, q[i].tag), {7'd0, v & q[i].msk}, {7'd0, q[i].exp & q[i].msk});
      chk($sformatf("select_excl%0d", i), {31'd0, $countones({b.Gra, b.Grb, b.Grc}) <= 1 && !(b.Rin && b.Rout)}, 32'd1);
      cyc[q[i].tag]++;
      rd[q[i].tag] += int'(b.Read);
      wr[q[i].tag] += int'(b.Write);
      rin[q[i].tag] += int'(b.Rin);
      pcin[q[i].tag] += int'(b.PCin);
      runlo[q[i].tag] += int'(!b.run);
      ill[q[i].tag] += int'(b.illegal);
    end
    chk("add_cycles", cyc[1], 6);
    chk("add_rin", rin[1], 1);
    chk("ld_read_cycles", rd[2], 5);
    chk("ld_cycles", cyc[2], 11);
    chk("st_rin", rin[3], 0);
    chk("st_write_cycles", wr[3], 3);
    chk("halt_run_low", runlo[4], 20);
    chk("halt_cycles", cyc[4], 24);
    chk("abort_pcin_once", pcin[5], 1);
    chk("abort_rin_once", rin[5], 1);
`ifdef ILLEGAL_TRAP_EN
    chk("illegal_sticky", ill[9], 5);
`else
    chk("illegal_as_nop", cyc[9], 4);
    chk("illegal_tied", ill[9], 0);
`endif
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
